// File: rtl/shift_reg_univ.sv
// ---------------------------------------------------------------------------
// shift_reg_univ
//
// Parametrised universal shift register with a counted multi-step engine.
// Single-step modes (hold, shift L/R, load, rotate L/R, arithmetic shift R)
// execute one step per clock edge. A start request in a shifting mode
// latches the mode, the serial inputs and the amount, then runs that many
// steps while busy is high. done pulses for one cycle when the run ends.
//
// Ports
//   clk     : system clock, rising-edge active
//   clear   : asynchronous active-high reset
//   mode    : operation select (000 hold, 001 shr, 010 shl, 011 load,
//             100 rotr, 101 rotl, 110 asr, 111 hold)
//   SL      : serial input entering Q[0] on shift-left
//   SR      : serial input entering Q[WIDTH-1] on shift-right
//   PData   : parallel load data
//   start   : request a multi-step shift of 'amount' positions
//   amount  : step count for start, 0..WIDTH-1
//   Q       : register contents
//   SO_L    : Q[WIDTH-1] (combinational)
//   SO_R    : Q[0] (combinational)
//   busy    : multi-step shift in progress
//   done    : one-cycle pulse when a multi-step shift completes
// ---------------------------------------------------------------------------
module shift_reg_univ #(
    parameter  int WIDTH = 32,
    localparam int AW    = $clog2(WIDTH)
) (
    input  logic             clk,
    input  logic             clear,
    input  logic [2:0]       mode,
    input  logic             SL,
    input  logic             SR,
    input  logic [WIDTH-1:0] PData,
    input  logic             start,
    input  logic [AW-1:0]    amount,
    output logic [WIDTH-1:0] Q,
    output logic             SO_L,
    output logic             SO_R,
    output logic             busy,
    output logic             done
);

    typedef enum logic {
        S_IDLE = 1'b0,
        S_RUN  = 1'b1
    } state_t;

    state_t           r_state;
    logic [WIDTH-1:0] r_q;
    logic [AW-1:0]    r_cnt;
    logic [2:0]       r_mode;
    logic             r_sl;
    logic             r_sr;
    logic             r_busy;
    logic             r_done;

    state_t           w_state_nxt;
    logic [WIDTH-1:0] w_q_nxt;
    logic [AW-1:0]    w_cnt_nxt;
    logic [2:0]       w_mode_nxt;
    logic             w_sl_nxt;
    logic             w_sr_nxt;
    logic             w_busy_nxt;
    logic             w_done_nxt;

    // One step of a shifting mode; any other code (hold, load, reserved)
    // returns the register unchanged so load must be handled by the caller.
    function automatic logic [WIDTH-1:0] f_step(
        input logic [2:0]       m,
        input logic [WIDTH-1:0] q,
        input logic             sl,
        input logic             sr
    );
        logic [WIDTH-1:0] res;
        res = q;
        case (m)
            3'b001:  res = {sr,       q[WIDTH-1:1]};
            3'b010:  res = {q[WIDTH-2:0], sl};
            3'b100:  res = {q[0],     q[WIDTH-1:1]};
            3'b101:  res = {q[WIDTH-2:0], q[WIDTH-1]};
            3'b110:  res = {q[WIDTH-1], q[WIDTH-1:1]};
            default: res = q;
        endcase
        return res;
    endfunction

    // Modes that may be repeated by the multi-step engine.
    function automatic logic f_is_shift(input logic [2:0] m);
        return (m == 3'b001) || (m == 3'b010) || (m == 3'b100) ||
               (m == 3'b101) || (m == 3'b110);
    endfunction

    always_comb begin
        w_state_nxt = r_state;
        w_q_nxt     = r_q;
        w_cnt_nxt   = r_cnt;
        w_mode_nxt  = r_mode;
        w_sl_nxt    = r_sl;
        w_sr_nxt    = r_sr;
        w_busy_nxt  = r_busy;
        w_done_nxt  = 1'b0;

        case (r_state)
            S_IDLE: begin
                w_busy_nxt = 1'b0;
                if (start && f_is_shift(mode)) begin
                    // Q holds on the accepting edge; steps begin next edge.
                    if (amount == '0) begin
                        w_done_nxt = 1'b1;
                    end else begin
                        w_mode_nxt  = mode;
                        w_sl_nxt    = SL;
                        w_sr_nxt    = SR;
                        w_cnt_nxt   = amount;
                        w_busy_nxt  = 1'b1;
                        w_state_nxt = S_RUN;
                    end
                end else if (mode == 3'b011) begin
                    w_q_nxt = PData;
                end else begin
                    w_q_nxt = f_step(mode, r_q, SL, SR);
                end
            end
            S_RUN: begin
                w_q_nxt   = f_step(r_mode, r_q, r_sl, r_sr);
                w_cnt_nxt = r_cnt - 1'b1;
                // Last step: drop busy and raise done on this same edge.
                if (r_cnt == AW'(1)) begin
                    w_busy_nxt  = 1'b0;
                    w_done_nxt  = 1'b1;
                    w_state_nxt = S_IDLE;
                end else begin
                    w_busy_nxt  = 1'b1;
                end
            end
            default: begin
                w_busy_nxt  = 1'b0;
                w_state_nxt = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or posedge clear) begin
        if (clear) begin
            r_state <= S_IDLE;
            r_q     <= '0;
            r_cnt   <= '0;
            r_mode  <= 3'b000;
            r_sl    <= 1'b0;
            r_sr    <= 1'b0;
            r_busy  <= 1'b0;
            r_done  <= 1'b0;
        end else begin
            r_state <= w_state_nxt;
            r_q     <= w_q_nxt;
            r_cnt   <= w_cnt_nxt;
            r_mode  <= w_mode_nxt;
            r_sl    <= w_sl_nxt;
            r_sr    <= w_sr_nxt;
            r_busy  <= w_busy_nxt;
            r_done  <= w_done_nxt;
        end
    end

    assign Q    = r_q;
    assign SO_L = r_q[WIDTH-1];
    assign SO_R = r_q[0];
    assign busy = r_busy;
    assign done = r_done;

endmodule

// File: tb/tb_shift_reg_univ.sv
// ---------------------------------------------------------------------------
// tb_shift_reg_univ
//
// Scoreboard bench for shift_reg_univ at WIDTH=32 and WIDTH=8. Stimulus
// pushes the expected register/handshake state for a given clock edge into
// a queue; the monitor pops and compares at two sample points per cycle
// (falling edge, and just before the next rising edge for async clears).
// ---------------------------------------------------------------------------
module tb_shift_reg_univ;

    typedef struct {
        int          cyc;
        int          ph;
        int          dut;
        logic [63:0] q;
        logic        busy;
        logic        done;
        string       name;
    } exp_t;

    logic        clk;
    logic        clear;
    logic [2:0]  mode;
    logic        SL;
    logic        SR;
    logic [31:0] PData;
    logic        st32;
    logic        st8;
    logic [4:0]  am32;
    logic [2:0]  am8;

    logic [31:0] q32;
    logic        sol32, sor32, busy32, done32;
    logic [7:0]  q8;
    logic        sol8, sor8, busy8, done8;

    exp_t sb[$];
    int   cyc_no = 0;
    int   total  = 0;
    int   bad    = 0;

    shift_reg_univ #(.WIDTH(32)) dut32 (
        .clk(clk), .clear(clear), .mode(mode), .SL(SL), .SR(SR),
        .PData(PData), .start(st32), .amount(am32),
        .Q(q32), .SO_L(sol32), .SO_R(sor32), .busy(busy32), .done(done32)
    );

    shift_reg_univ #(.WIDTH(8)) dut8 (
        .clk(clk), .clear(clear), .mode(mode), .SL(SL), .SR(SR),
        .PData(PData[7:0]), .start(st8), .amount(am8),
        .Q(q8), .SO_L(sol8), .SO_R(sor8), .busy(busy8), .done(done8)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) cyc_no <= cyc_no + 1;

    task automatic check_phase(input int ph);
        exp_t        e;
        logic [63:0] aq;
        logic        ab, ad, asl, asr, esl, esr;
        while (sb.size() > 0 &&
               (sb[0].cyc < cyc_no || (sb[0].cyc == cyc_no && sb[0].ph <= ph))) begin
            e = sb.pop_front();
            if (e.dut == 0) begin
                aq  = {32'b0, q32};
                ab  = busy32; ad = done32; asl = sol32; asr = sor32;
                esl = e.q[31];
            end else begin
                aq  = {56'b0, q8};
                ab  = busy8;  ad = done8;  asl = sol8;  asr = sor8;
                esl = e.q[7];
            end
            esr = e.q[0];
            total++;
            if (e.cyc != cyc_no || aq !== e.q || ab !== e.busy || ad !== e.done ||
                asl !== esl || asr !== esr) begin
                bad++;
                $display("FAIL %s (cyc %0d): got q=%h busy=%b done=%b sol=%b sor=%b, want q=%h busy=%b done=%b sol=%b sor=%b",
                         e.name, e.cyc, aq, ab, ad, asl, asr, e.q, e.busy, e.done, esl, esr);
            end
        end
    endtask

    // Monitor: falling edge, then once more shortly before the rising edge.
    always @(negedge clk) begin
        check_phase(0);
        #3;
        check_phase(1);
    end

    task automatic push(input int cyc, input int ph, input int d, input logic [63:0] q,
                        input logic b, input logic dn, input string nm);
        exp_t e;
        e.cyc = cyc; e.ph = ph; e.dut = d; e.q = q; e.busy = b; e.done = dn; e.name = nm;
        sb.push_back(e);
    endtask

    // Drive inputs for the next rising edge and expect the state after it.
    task automatic step(input int d, input logic [2:0] m, input logic sl, input logic sr,
                        input logic [31:0] pd, input logic st, input int am,
                        input logic [63:0] eq, input logic eb, input logic ed,
                        input string nm);
        mode  = m;
        SL    = sl;
        SR    = sr;
        PData = pd;
        if (d == 0) begin
            st32 = st; am32 = am[4:0]; st8 = 1'b0; am8 = 3'd0;
        end else begin
            st8 = st; am8 = am[2:0]; st32 = 1'b0; am32 = 5'd0;
        end
        push(cyc_no + 1, 0, d, eq, eb, ed, nm);
        @(posedge clk);
        #2;
    endtask

    // Assert clear between edges; outputs must be zero before the next edge.
    task automatic do_clear(input int d);
        @(negedge clk);
        #1;
        clear = 1'b1;
        push(cyc_no, 1, d, 64'h0, 1'b0, 1'b0, "async_clear");
        @(posedge clk);
        #2;
        clear = 1'b0;
    endtask

    initial begin
        clear = 1'b1; mode = 3'b000; SL = 1'b0; SR = 1'b0; PData = 32'h0;
        st32 = 1'b0; st8 = 1'b0; am32 = 5'd0; am8 = 3'd0;
        do_clear(0);

        // ---------------- WIDTH = 32 ----------------
        for (int i = 1; i <= 32; i++)
            step(0, 3'b001, 1'b0, 1'b1, 32'h0, 1'b0, 0,
                 (64'hFFFF_FFFF << (32 - i)) & 64'hFFFF_FFFF, 1'b0, 1'b0, "fill32");
        for (int i = 1; i <= 32; i++)
            step(0, 3'b010, 1'b0, 1'b0, 32'h0, 1'b0, 0,
                 (64'hFFFF_FFFF << i) & 64'hFFFF_FFFF, 1'b0, 1'b0, "drain32");

        step(0, 3'b011, 0, 0, 32'h8000_0001, 0, 0, 64'h8000_0001, 0, 0, "load32");
        step(0, 3'b100, 0, 0, 32'h0,         0, 0, 64'hC000_0000, 0, 0, "rotr32");
        step(0, 3'b011, 0, 0, 32'h8000_0001, 0, 0, 64'h8000_0001, 0, 0, "reload32");
        step(0, 3'b101, 0, 0, 32'h0,         0, 0, 64'h0000_0003, 0, 0, "rotl32");
        step(0, 3'b011, 0, 0, 32'h8000_0000, 0, 0, 64'h8000_0000, 0, 0, "load_asr32");
        step(0, 3'b110, 0, 0, 32'h0,         0, 0, 64'hC000_0000, 0, 0, "asr32_1");
        step(0, 3'b110, 0, 0, 32'h0,         0, 0, 64'hE000_0000, 0, 0, "asr32_2");
        step(0, 3'b110, 0, 0, 32'h0,         0, 0, 64'hF000_0000, 0, 0, "asr32_3");
        step(0, 3'b000, 1, 1, 32'h1234_5678, 0, 0, 64'hF000_0000, 0, 0, "hold32");
        step(0, 3'b111, 1, 1, 32'h1234_5678, 0, 0, 64'hF000_0000, 0, 0, "reserved32");

        // Multi-step rotate right by 5; inputs toggled during the run.
        step(0, 3'b011, 0, 0, 32'h8000_0001, 0, 0, 64'h8000_0001, 0, 0, "mrot_load");
        step(0, 3'b100, 0, 0, 32'h0,         1, 5, 64'h8000_0001, 1, 0, "mrot_start");
        step(0, 3'b011, 1, 1, 32'hDEAD_BEEF, 1, 3, 64'hC000_0000, 1, 0, "mrot_s1");
        step(0, 3'b010, 0, 1, 32'hDEAD_BEEF, 0, 3, 64'h6000_0000, 1, 0, "mrot_s2");
        step(0, 3'b011, 1, 0, 32'hCAFE_F00D, 1, 1, 64'h3000_0000, 1, 0, "mrot_s3");
        step(0, 3'b001, 1, 1, 32'hDEAD_BEEF, 0, 2, 64'h1800_0000, 1, 0, "mrot_s4");
        step(0, 3'b011, 0, 0, 32'hFFFF_FFFF, 0, 0, 64'h0C00_0000, 0, 1, "mrot_done");
        step(0, 3'b000, 0, 0, 32'h0,         0, 0, 64'h0C00_0000, 0, 0, "mrot_after");

        // Latched SR: SR changes during the run must not matter.
        step(0, 3'b011, 0, 0, 32'h0, 0, 0, 64'h0,         0, 0, "lsr_load");
        step(0, 3'b001, 0, 1, 32'h0, 1, 3, 64'h0,         1, 0, "lsr_start");
        step(0, 3'b010, 0, 0, 32'h0, 0, 0, 64'h8000_0000, 1, 0, "lsr_s1");
        step(0, 3'b010, 0, 0, 32'h0, 0, 0, 64'hC000_0000, 1, 0, "lsr_s2");
        step(0, 3'b000, 0, 0, 32'h0, 0, 0, 64'hE000_0000, 0, 1, "lsr_done");

        // amount = 0 and start with a non-shift mode.
        step(0, 3'b001, 0, 1, 32'h0,         1, 0, 64'hE000_0000, 0, 1, "amt0");
        step(0, 3'b000, 0, 0, 32'h0,         0, 0, 64'hE000_0000, 0, 0, "amt0_after");
        step(0, 3'b011, 0, 0, 32'h1234_5678, 1, 4, 64'h1234_5678, 0, 0, "start_load");
        step(0, 3'b000, 0, 0, 32'h0,         0, 0, 64'h1234_5678, 0, 0, "start_load_after");

        // Back-to-back: second start issued on the done cycle.
        step(0, 3'b101, 0, 0, 32'h0,         1, 2, 64'h1234_5678, 1, 0, "b2b_start1");
        step(0, 3'b011, 0, 0, 32'hFFFF_FFFF, 1, 3, 64'h2468_ACF0, 1, 0, "b2b_s1");
        step(0, 3'b000, 0, 0, 32'h0,         0, 0, 64'h48D1_59E0, 0, 1, "b2b_done1");
        step(0, 3'b100, 0, 0, 32'h0,         1, 1, 64'h48D1_59E0, 1, 0, "b2b_start2");
        step(0, 3'b000, 0, 0, 32'h0,         0, 0, 64'h2468_ACF0, 0, 1, "b2b_done2");
        step(0, 3'b000, 0, 0, 32'h0,         0, 0, 64'h2468_ACF0, 0, 0, "b2b_after");

        // Mid-run clear at step 2 of a 7-step run, then a fresh run.
        step(0, 3'b011, 0, 0, 32'h1, 0, 0, 64'h1, 0, 0, "mid_load");
        step(0, 3'b010, 1, 0, 32'h0, 1, 7, 64'h1, 1, 0, "mid_start");
        step(0, 3'b000, 0, 0, 32'h0, 0, 0, 64'h3, 1, 0, "mid_s1");
        step(0, 3'b000, 0, 0, 32'h0, 0, 0, 64'h7, 1, 0, "mid_s2");
        do_clear(0);
        step(0, 3'b011, 0, 0, 32'h1, 0, 0, 64'h1, 0, 0, "post_load");
        step(0, 3'b101, 0, 0, 32'h0, 1, 2, 64'h1, 1, 0, "post_start");
        step(0, 3'b000, 0, 0, 32'h0, 0, 0, 64'h2, 1, 0, "post_s1");
        step(0, 3'b000, 0, 0, 32'h0, 0, 0, 64'h4, 0, 1, "post_done");
        step(0, 3'b000, 0, 0, 32'h0, 0, 0, 64'h4, 0, 0, "post_after");

        // ---------------- WIDTH = 8 ----------------
        do_clear(1);
        for (int i = 1; i <= 8; i++)
            step(1, 3'b001, 1'b0, 1'b1, 32'h0, 1'b0, 0,
                 (64'hFF << (8 - i)) & 64'hFF, 1'b0, 1'b0, "fill8");
        for (int i = 1; i <= 8; i++)
            step(1, 3'b010, 1'b0, 1'b0, 32'h0, 1'b0, 0,
                 (64'hFF << i) & 64'hFF, 1'b0, 1'b0, "drain8");

        step(1, 3'b011, 0, 0, 32'h81, 0, 0, 64'h81, 0, 0, "load8");
        step(1, 3'b100, 0, 0, 32'h0,  0, 0, 64'hC0, 0, 0, "rotr8");
        step(1, 3'b011, 0, 0, 32'h81, 0, 0, 64'h81, 0, 0, "reload8");
        step(1, 3'b101, 0, 0, 32'h0,  0, 0, 64'h03, 0, 0, "rotl8");
        step(1, 3'b011, 0, 0, 32'h80, 0, 0, 64'h80, 0, 0, "load_asr8");
        step(1, 3'b110, 0, 0, 32'h0,  0, 0, 64'hC0, 0, 0, "asr8_1");
        step(1, 3'b110, 0, 0, 32'h0,  0, 0, 64'hE0, 0, 0, "asr8_2");
        step(1, 3'b110, 0, 0, 32'h0,  0, 0, 64'hF0, 0, 0, "asr8_3");

        step(1, 3'b011, 0, 0, 32'h81, 0, 0, 64'h81, 0, 0, "mrot8_load");
        step(1, 3'b100, 0, 0, 32'h0,  1, 5, 64'h81, 1, 0, "mrot8_start");
        step(1, 3'b011, 1, 1, 32'h55, 1, 2, 64'hC0, 1, 0, "mrot8_s1");
        step(1, 3'b011, 1, 1, 32'h55, 0, 2, 64'h60, 1, 0, "mrot8_s2");
        step(1, 3'b001, 0, 1, 32'hAA, 1, 1, 64'h30, 1, 0, "mrot8_s3");
        step(1, 3'b010, 1, 0, 32'hAA, 0, 1, 64'h18, 1, 0, "mrot8_s4");
        step(1, 3'b000, 0, 0, 32'h0,  0, 0, 64'h0C, 0, 1, "mrot8_done");
        step(1, 3'b000, 0, 0, 32'h0,  0, 0, 64'h0C, 0, 0, "mrot8_after");

        // Largest amount for WIDTH=8: rotate left by 7.
        step(1, 3'b011, 0, 0, 32'h01, 0, 0, 64'h01, 0, 0, "max8_load");
        step(1, 3'b101, 0, 0, 32'h0,  1, 7, 64'h01, 1, 0, "max8_start");
        for (int i = 1; i <= 7; i++)
            step(1, 3'b000, 0, 0, 32'h0, 0, 0, 64'h1 << i, (i < 7), (i == 7), "max8_step");
        step(1, 3'b000, 0, 0, 32'h0, 0, 0, 64'h80, 0, 0, "max8_after");

        for (int i = 0; i < 20 && sb.size() > 0; i++) @(negedge clk);
        #4;
        if (sb.size() != 0) begin
            total++;
            bad++;
            $display("FAIL drain_scoreboard: got %0d pending, want 0", sb.size());
        end
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/shift_reg_univ.md
# shift_reg_univ

Parametrised universal shift register; successor to the fixed 32-bit four-mode shifter. It adds configurable width, rotate and arithmetic-shift modes, and a multi-step shift engine that runs a counted shift of 0..WIDTH-1 positions under a start/busy/done handshake. It serves as the datapath shifter/serial converter in the lab CPU and peripheral designs.

## Interface
- WIDTH, 32, register width in bits; legal range 2..64.
- AW (localparam), $clog2(WIDTH), width of the amount port.

- clk  in  1  system clock; all state updates on its rising edge.
- clear  in  1  reset, asynchronous, active-high; the only reset.
- mode  in  3  operation select (see Operation).
- SL  in  1  serial input for shift-left (enters Q[0]).
- SR  in  1  serial input for shift-right (enters Q[WIDTH-1]).
- PData  in  WIDTH  parallel load data.
- start  in  1  request a multi-step shift of amount positions.
- amount  in  AW  step count for start, 0..WIDTH-1.
- Q  out  WIDTH  register contents.
- SO_L  out  1  Q[WIDTH-1], combinational.
- SO_R  out  1  Q[0], combinational.
- busy  out  1  multi-step shift in progress.
- done  out  1  one-cycle pulse when a multi-step shift completes.

## Operation
- Mode encoding, one step per edge:
  - 000: hold.
  - 001: shift right, Q <= {SR, Q[W-1:1]}.
  - 010: shift left, Q <= {Q[W-2:0], SL}.
  - 011: load, Q <= PData.
  - 100: rotate right, Q <= {Q[0], Q[W-1:1]}.
  - 101: rotate left, Q <= {Q[W-2:0], Q[W-1]}.
  - 110: arithmetic shift right, Q <= {Q[W-1], Q[W-1:1]}.
  - 111: reserved; acts as hold.
- FSM states IDLE and RUN.
- IDLE with start=0: apply the mode step every edge.
- IDLE, start=1, mode in {001, 010, 100, 101, 110}, amount>0:
  - Latch mode, SL, SR, and count=amount.
  - Q unchanged on this edge.
  - Go to RUN.
- IDLE, start=1, shifting mode, amount=0: Q unchanged, done pulses, stay in IDLE.
- IDLE, start=1, mode in {000, 011, 111}: start is ignored and the mode executes normally; no done pulse.
- RUN:
  - Each edge applies one step of the latched mode, using the latched SL/SR, then decrements count.
  - When count reaches 0, return to IDLE and pulse done.
- In RUN, mode, start, amount, PData, SL and SR are ignored.
- Reset, at any time including mid-RUN: Q=0, busy=0, done=0, count=0, state=IDLE. Takes effect immediately, without waiting for clk.

## Timing
- Single-step modes: Q updates on the edge where mode is sampled; latency 1 edge.
- Multi-step: start sampled at edge k; steps occur at edges k+1 .. k+amount.
  - busy=1 from edge k to edge k+amount.
  - done=1 from edge k+amount to edge k+amount+1.
  - Total latency amount+1 edges.
- amount=0: busy never asserts; done=1 for the one cycle after edge k.
- A start asserted while done is high (first IDLE cycle) is accepted; back-to-back runs are allowed.
- All outputs are registered except SO_L and SO_R.
- After reset release, the first edge behaves as IDLE.

## Test plan
- Reset then fill (WIDTH=32): pulse clear; mode=001, SR=1 for 32 edges.
  - Q=0 immediately on clear (before any edge).
  - Q=0xFFFFFFFF after 32 edges.
- Shift-left drain: from Q=0xFFFFFFFF, mode=010, SL=0 for 32 edges -> Q=0x00000000; SO_L=0 after the last edge.
- Load and single rotate/arithmetic steps:
  - Load 0x80000001.
  - One rotate-right -> 0xC0000000.
  - Reload 0x80000001; one rotate-left -> 0x00000003.
  - Load 0x80000000; three arithmetic-right steps -> 0xF0000000.
- Multi-step rotate: Q=0x80000001, mode=100, start=1, amount=5 for one cycle.
  - busy high for 5 cycles.
  - Q=0x0C000000.
  - done is a single pulse at the 5th step edge.
  - Toggling mode and PData during RUN has no effect.
- Corner handshakes:
  - amount=0 -> done pulse, no busy, Q unchanged.
  - start with mode=011 -> plain load, no done.
  - Back-to-back start on the done cycle -> second run executes.
- Mid-run reset, then narrow build:
  - Assert clear at step 2 of an amount=7 run -> Q=0, busy=0, done=0 at once; next start works normally.
  - Repeat the fill/drain and rotate scenarios with WIDTH=8.
